sbp_pipeline_arbiter: RTL and testbench

SBP_PIPELINE_ARBITER -- requirements
Module: sbp_pipeline_arbiter

---
 rtl/sbp_pipeline_arbiter.sv | 136 +++++++++++++
 tb/tb_sbp_pipeline_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sbp_pipeline_arbiter.sv
// sbp_pipeline_arbiter: arbitrates queued table updates against lookups onto one pipeline-head slot.
// Define SBP_ARB_DRAIN_EN to insert a PIPE_STAGES-cycle drain after the update that empties the queue.
module sbp_pipeline_arbiter #(
  parameter int STAGE_ID_BITS  = 6,
  parameter int LOCATION_BITS  = 11,
  parameter int RESULT_BITS    = 24,
  parameter int ROOT_STAGE_ID  = 1,
  parameter int UPD_FIFO_DEPTH = 4,
  parameter int UPD_BURST      = 2,
  parameter int PIPE_STAGES    = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                lkp_valid_i,
  output logic                                lkp_ready_o,
  input  logic [31:0]                         lkp_ip_addr_i,
  input  logic                                upd_valid_i,
  output logic                                upd_ready_o,
  input  logic [31:0]                         upd_prefix_i,
  input  logic [5:0]                          upd_prefix_len_i,
  input  logic [STAGE_ID_BITS-1:0]            upd_stage_id_i,
  input  logic [LOCATION_BITS-1:0]            upd_location_i,
  input  logic [RESULT_BITS-1:0]              upd_result_i,
  output logic                                valid_o,
  output logic                                update_o,
  output logic [31:0]                         ip_addr_o,
  output logic [5:0]                          bit_pos_o,
  output logic [STAGE_ID_BITS-1:0]            stage_id_o,
  output logic [LOCATION_BITS-1:0]            location_o,
  output logic [RESULT_BITS-1:0]              result_o,
  output logic [$clog2(UPD_FIFO_DEPTH):0]     upd_count_o
);
  localparam int AW = $clog2(UPD_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(UPD_BURST + 1);

  typedef struct packed {
    logic [31:0]              prefix;
    logic [5:0]               len;
    logic [STAGE_ID_BITS-1:0] stage;
    logic [LOCATION_BITS-1:0] location;
    logic [RESULT_BITS-1:0]   result;
  } upd_t;

`ifdef SBP_ARB_DRAIN_EN
  typedef enum logic [1:0] {IDLE, LKP, UPD, DRAIN} state_t;
  localparam int DW = $clog2(PIPE_STAGES + 1);
  logic [DW-1:0] drain_cnt, drain_nxt;
`else
  typedef enum logic [1:0] {IDLE, LKP, UPD} state_t;
`endif

  upd_t          mem [UPD_FIFO_DEPTH];
  upd_t          head;
  state_t        state, state_nxt;
  logic [CW-1:0] wr_ptr, rd_ptr, count;
  logic [BW-1:0] burst_cnt;
  logic          burst_sat, empty, full, in_drain, enq, issue_upd, issue_lkp;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign count       = wr_ptr - rd_ptr;
  assign empty       = count == '0;
  assign full        = count == CW'(UPD_FIFO_DEPTH);
  assign burst_sat   = burst_cnt >= BW'(UPD_BURST);
  assign head        = mem[rd_ptr[AW-1:0]];
  assign upd_count_o = count;

`ifdef SBP_ARB_DRAIN_EN
  assign in_drain = state == DRAIN;
`else
  assign in_drain = 1'b0;
  logic unused_drain;
  assign unused_drain = ^{state, 32'(PIPE_STAGES)};
`endif

  // Readies are forced low while reset is held, like every other output.
  assign lkp_ready_o = rst && !in_drain && (empty || burst_sat);
  assign upd_ready_o = rst && !full;
  assign enq         = upd_valid_i && upd_ready_o;
  assign issue_upd   = !in_drain && !empty && !(lkp_valid_i && burst_sat);
  assign issue_lkp   = lkp_valid_i && lkp_ready_o;

`ifdef SBP_ARB_DRAIN_EN
  always_comb begin
    state_nxt = issue_upd ? UPD : issue_lkp ? LKP : IDLE;
    drain_nxt = '0;
    if (in_drain) begin
      state_nxt = drain_cnt == '0 ? IDLE : DRAIN;
      drain_nxt = drain_cnt == '0 ? '0 : drain_cnt - 1'b1;
    end else if (issue_upd && count == CW'(1) && !enq) begin
      state_nxt = DRAIN;
      drain_nxt = DW'(PIPE_STAGES - 1);
    end
  end
`else
  assign state_nxt = issue_upd ? UPD : issue_lkp ? LKP : IDLE;
`endif

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr[AW-1:0]] <= {upd_prefix_i, upd_prefix_len_i, upd_stage_id_i, upd_location_i, upd_result_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      valid_o    <= 1'b0;
      update_o   <= 1'b0;
      ip_addr_o  <= '0;
      bit_pos_o  <= '0;
      stage_id_o <= '0;
      location_o <= '0;
      result_o   <= '0;
`ifdef SBP_ARB_DRAIN_EN
      drain_cnt  <= '0;
`endif
    end else begin
      state      <= state_nxt;
      burst_cnt  <= issue_upd ? (burst_sat ? burst_cnt : burst_cnt + 1'b1) : '0;
      wr_ptr     <= wr_ptr + CW'(enq);
      rd_ptr     <= rd_ptr + CW'(issue_upd);
      valid_o    <= issue_upd || issue_lkp;
      update_o   <= issue_upd;
      ip_addr_o  <= issue_upd ? head.prefix : issue_lkp ? lkp_ip_addr_i : '0;
      bit_pos_o  <= issue_upd ? head.len : '0;
      stage_id_o <= issue_upd ? head.stage : issue_lkp ? STAGE_ID_BITS'(ROOT_STAGE_ID) : '0;
      location_o <= issue_upd ? head.location : '0;
      result_o   <= issue_upd ? head.result : '0;
`ifdef SBP_ARB_DRAIN_EN
      drain_cnt  <= drain_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_sbp_pipeline_arbiter.sv
// tb_sbp_pipeline_arbiter: directed and random stimulus against a slot-level scoreboard.
// Expectations follow SBP_ARB_DRAIN_EN when it is defined for the build.
module tb_sbp_pipeline_arbiter;
  localparam int SB = 6, LB = 11, RB = 24, DEPTH = 4, BURST = 2, STAGES = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          lkp_valid = 1'b0, upd_valid = 1'b0;
  logic          lkp_ready_o, upd_ready_o;
  logic [31:0]   lkp_ip = '0, upd_prefix = '0;
  logic [5:0]    upd_len = '0;
  logic [SB-1:0] upd_stage = '0;
  logic [LB-1:0] upd_loc = '0;
  logic [RB-1:0] upd_res = '0;
  logic          valid_o, update_o;
  logic [31:0]   ip_addr_o;
  logic [5:0]    bit_pos_o;
  logic [SB-1:0] stage_id_o;
  logic [LB-1:0] location_o;
  logic [RB-1:0] result_o;
  logic [2:0]    upd_count_o;

  typedef struct packed {
    logic          v;
    logic          u;
    logic [31:0]   ip;
    logic [5:0]    bp;
    logic [SB-1:0] st;
    logic [LB-1:0] loc;
    logic [RB-1:0] res;
  } slot_t;

  slot_t exp_q[$];
  slot_t m_fifo[$];
  int    m_burst = 0, m_drain = 0;
  int    errors = 0, checks = 0;

  always #5 clk = ~clk;

  sbp_pipeline_arbiter #(
    .STAGE_ID_BITS(SB), .LOCATION_BITS(LB), .RESULT_BITS(RB), .ROOT_STAGE_ID(1),
    .UPD_FIFO_DEPTH(DEPTH), .UPD_BURST(BURST), .PIPE_STAGES(STAGES)
  ) dut (
    .clk(clk), .rst(rst),
    .lkp_valid_i(lkp_valid), .lkp_ready_o(lkp_ready_o), .lkp_ip_addr_i(lkp_ip),
    .upd_valid_i(upd_valid), .upd_ready_o(upd_ready_o),
    .upd_prefix_i(upd_prefix), .upd_prefix_len_i(upd_len), .upd_stage_id_i(upd_stage),
    .upd_location_i(upd_loc), .upd_result_i(upd_res),
    .valid_o(valid_o), .update_o(update_o), .ip_addr_o(ip_addr_o), .bit_pos_o(bit_pos_o),
    .stage_id_o(stage_id_o), .location_o(location_o), .result_o(result_o),
    .upd_count_o(upd_count_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic slot_t dut_slot();
    return {valid_o, update_o, ip_addr_o, bit_pos_o, stage_id_o, location_o, result_o};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: decides each edge's slot from the inputs and queues the expected output.
  always @(posedge clk) begin : model
    slot_t s;
    bit    ur;
    s  = '0;
    ur = m_fifo.size() < DEPTH;
    if (rst) begin
      if (m_drain > 0) begin
        m_drain--;
        m_burst = 0;
      end else if (m_fifo.size() != 0 && !(lkp_valid && m_burst >= BURST)) begin
        s = m_fifo.pop_front();
        m_burst = m_burst < BURST ? m_burst + 1 : BURST;
`ifdef SBP_ARB_DRAIN_EN
        if (m_fifo.size() == 0 && !(upd_valid && ur)) m_drain = STAGES;
`endif
      end else if (lkp_valid) begin
        s = {1'b1, 1'b0, lkp_ip, 6'd0, SB'(1), LB'(0), RB'(0)};
        m_burst = 0;
      end else m_burst = 0;
      if (upd_valid && ur) m_fifo.push_back({1'b1, 1'b1, upd_prefix, upd_len, upd_stage, upd_loc, upd_res});
      exp_q.push_back(s);
    end
  end

  always @(negedge rst) begin
    m_fifo.delete();
    exp_q.delete();
    m_burst = 0;
    m_drain = 0;
  end

  always @(negedge clk) begin : scoreboard
    slot_t e;
    if (!rst) begin
      chk("rst_slot", dut_slot(), '0);
      chk("rst_ready", {lkp_ready_o, upd_ready_o}, '0);
      chk("rst_count", upd_count_o, '0);
    end else begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : '0;
      chk("slot", dut_slot(), e);
      chk("lkp_ready", lkp_ready_o, m_drain == 0 && (m_fifo.size() == 0 || m_burst >= BURST));
      chk("upd_ready", upd_ready_o, m_fifo.size() < DEPTH);
      chk("upd_count", upd_count_o, m_fifo.size());
    end
  end

  task automatic set_upd(input logic [31:0] p, input logic [5:0] l, input logic [SB-1:0] s,
                         input logic [LB-1:0] loc, input logic [RB-1:0] r);
    upd_valid  = 1'b1;
    upd_prefix = p;
    upd_len    = l;
    upd_stage  = s;
    upd_loc    = loc;
    upd_res    = r;
  endtask

  initial begin
    logic [11:0] pattern;
    int          max_cnt, seen, bubbles;
    bit          saw_full, found;
    step(3);
    #2 rst = 1'b1;
    step();
    // Single lookup with an empty queue
    lkp_valid = 1'b1;
    lkp_ip    = 32'h0A00_0001;
    step();
    lkp_valid = 1'b0;
    chk("lkp_only", {valid_o, update_o, stage_id_o, location_o, bit_pos_o, ip_addr_o},
        {1'b1, 1'b0, SB'(1), LB'(0), 6'd0, 32'h0A00_0001});
    // Single update: queued on one edge, issued on the next
    set_upd(32'hC0A8_0000, 6'd16, SB'(3), LB'(5), RB'(24'h123456));
    step();
    upd_valid = 1'b0;
    step();
    chk("upd_only", {valid_o, update_o, stage_id_o, location_o, bit_pos_o, ip_addr_o, result_o},
        {1'b1, 1'b1, SB'(3), LB'(5), 6'd16, 32'hC0A8_0000, RB'(24'h123456)});
    step(20);
    // Contention: lookup held valid while four updates arrive
    lkp_valid = 1'b1;
    lkp_ip    = 32'h0B00_0002;
    pattern   = '0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) set_upd(32'h1000_0000 + 32'(i), 6'(8 + i), SB'(2 + i), LB'(10 + i), RB'(i));
      else upd_valid = 1'b0;
      step();
      pattern = {pattern[9:0], valid_o, update_o};
    end
    chk("burst_order", pattern, 12'b10_11_11_10_11_11);
    lkp_valid = 1'b0;
    step(20);
    // Sustained updates plus lookups push the queue to full
    lkp_valid = 1'b1;
    max_cnt   = 0;
    saw_full  = 1'b0;
    for (int i = 0; i < 24; i++) begin
      set_upd($urandom, 6'($urandom), SB'($urandom), LB'($urandom), RB'($urandom));
      step();
      if (int'(upd_count_o) > max_cnt) max_cnt = int'(upd_count_o);
      if (!upd_ready_o) saw_full = 1'b1;
    end
    chk("full_max_count", max_cnt, 4);
    chk("full_ready_low", saw_full, 1'b1);
    // Reset with three queued updates
    upd_valid = 1'b0;
    for (int i = 0; i < 10 && m_fifo.size() != 3; i++) step();
    chk("pre_rst_count", upd_count_o, 3);
    lkp_valid = 1'b0;
    #2 rst = 1'b0;
    #1 chk("rst_immediate", {dut_slot(), upd_count_o, upd_ready_o, lkp_ready_o}, '0);
    step(2);
    #2 rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen += int'(valid_o);
    end
    chk("post_rst_no_issue", seen, 0);
    // Update followed by a waiting lookup: drain gap between them
    set_upd(32'hAC10_0000, 6'd12, SB'(4), LB'(7), RB'(24'h00BEEF));
    step();
    upd_valid = 1'b0;
    lkp_valid = 1'b1;
    lkp_ip    = 32'h0C00_0003;
    found     = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      step();
      found = update_o;
    end
    chk("drain_upd_seen", found, 1'b1);
    bubbles = 0;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (valid_o) found = 1'b1;
      else bubbles++;
    end
    chk("drain_lkp_seen", {found, update_o, ip_addr_o}, {1'b1, 1'b0, 32'h0C00_0003});
`ifdef SBP_ARB_DRAIN_EN
    chk("drain_bubbles", bubbles, STAGES);
`else
    chk("drain_bubbles", bubbles, 0);
`endif
    lkp_valid = 1'b0;
    step(20);
    // Random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 400; i++) begin
      lkp_valid = 1'($urandom_range(0, 1));
      lkp_ip    = $urandom;
      set_upd($urandom, 6'($urandom), SB'($urandom), LB'($urandom), RB'($urandom));
      upd_valid = 1'($urandom_range(0, 2) != 0);
      step();
    end
    lkp_valid = 1'b0;
    upd_valid = 1'b0;
    step(25);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
